reg_port_arbiter: RTL and testbench

Arbitrates up to four word-level requesters onto the single byte-serial register port (valid/ready handshake, wr_n, 2-bit address, 8-bit data in each direction, 4-beat LSB-first bursts). Each requester issues one 32-bit read or write at a time; the arbiter grants round-robin, sequences the handshake and byte bursts, and returns one response per request. It sits between the bus masters and the 4×32-bit register block.

---
 rtl/reg_arb_pkg.sv | 51 +++++
 rtl/reg_port_arbiter_rr.sv | 56 +++++
 rtl/reg_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_reg_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-port arbiter.
// Byte lanes are little-endian: byte 0 is bits [7:0] and travels first on the bus.
package reg_arb_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned REG_ADDR_W     = 2;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  // Requester index width; covers NREQ up to 4.
  localparam int unsigned IDX_W          = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WBURST,
    S_RBURST,
    S_RESP
  } arb_state_e;

  // Extract byte lane idx from a word.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    b = w[7:0];
    case (idx)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Replace byte lane idx of a word.
  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        idx,
                                                 input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    case (idx)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      2'd3: r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_port_arbiter_rr.sv
// Round-robin grant over NREQ requesters. The search starts at the pointer;
// the pointer moves to one past the winner only when the grant is accepted.
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  localparam int unsigned CW = IDX_W + 1;

  logic [IDX_W-1:0] ptr;
  logic [CW-1:0]    cand;

  // Pick the first pending requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!grant_any && (cand == CW'(j)) && req[j]) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

  // One-hot view of the winner.
  always_comb begin
    grant = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      grant[j] = grant_any && (grant_idx == IDX_W'(j));
    end
  end

  // Pointer advances past the accepted winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Arbitrates NREQ word requesters onto the byte-serial register port.
// Sequence: grant (IDLE) -> address/byte0 handshake (REQ) -> write bytes 1..3
// (WBURST) or read bytes 0..3 (RBURST) -> one-cycle response (RESP).
// Optional: define REG_ARB_TIMEOUT_EN to abort REQ after TIMEOUT cycles with
// no handshake and return rsp_err_o=1.
module reg_port_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid_i,
  output logic [NREQ-1:0]              req_ready_o,
  input  logic [NREQ-1:0]              req_wr_n_i,
  input  logic [NREQ*REG_ADDR_W-1:0]   req_addr_i,
  input  logic [NREQ*WORD_W-1:0]       req_wdata_i,
  output logic [NREQ-1:0]              rsp_valid_o,
  output logic [WORD_W-1:0]            rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic                         bus_valid_o,
  input  logic                         bus_ready_i,
  output logic                         bus_wr_n_o,
  output logic [REG_ADDR_W-1:0]        bus_addr_o,
  output logic [BYTE_W-1:0]            bus_data_o,
  input  logic [BYTE_W-1:0]            bus_data_i
);

  localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);

  arb_state_e state, state_nxt;

  logic [NREQ-1:0]       grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  accept;
  logic                  handshake;
  logic                  tmo_hit;
  logic                  err_flag;

  logic                  sel_wr_n;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0]     sel_wdata;

  logic                  wr_n_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [WORD_W-1:0]     rdata_q;
  logic [IDX_W-1:0]      owner_q;
  logic [1:0]            beat_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid_i),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign accept    = (state == S_IDLE) && grant_any;
  assign handshake = (state == S_REQ) && bus_ready_i;

`ifdef REG_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_q;

  assign tmo_hit  = (state == S_REQ) && !bus_ready_i &&
                    (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
  assign err_flag = err_q;

  // Count consecutive REQ cycles; restarts every time REQ is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state != S_REQ) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Error flag for the current transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign err_flag = 1'b0;
`endif

  // Request fields of the current round-robin winner.
  always_comb begin
    sel_wr_n  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        sel_wr_n  = req_wr_n_i[j];
        sel_addr  = req_addr_i[j*REG_ADDR_W +: REG_ADDR_W];
        sel_wdata = req_wdata_i[j*WORD_W +: WORD_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and all port outputs; every output is idle-zero by default.
  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    bus_valid_o = 1'b0;
    bus_wr_n_o  = 1'b0;
    bus_addr_o  = '0;
    bus_data_o  = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          // Accept pulse is masked while reset is held so no requester
          // sees a grant that the state machine never takes.
          req_ready_o = grant & {NREQ{rst_n}};
          state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        bus_valid_o = 1'b1;
        bus_wr_n_o  = wr_n_q;
        bus_addr_o  = addr_q;
        bus_data_o  = wdata_q[7:0];
        if (bus_ready_i) begin
          state_nxt = wr_n_q ? S_RBURST : S_WBURST;
        end else if (tmo_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_WBURST: begin
        bus_data_o = word_byte(wdata_q, beat_q);
        if (beat_q == LAST_BEAT) state_nxt = S_RESP;
      end
      S_RBURST: begin
        if (beat_q == LAST_BEAT) state_nxt = S_RESP;
      end
      S_RESP: begin
        for (int unsigned j = 0; j < NREQ; j++) begin
          rsp_valid_o[j] = (owner_q == IDX_W'(j));
        end
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_flag;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transaction latches, beat counter and read assembly. rdata is cleared on
  // accept so writes and aborted transactions report zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_n_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      owner_q <= '0;
      beat_q  <= '0;
    end else begin
      if (accept) begin
        wr_n_q  <= sel_wr_n;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        owner_q <= grant_idx;
        rdata_q <= '0;
        beat_q  <= '0;
      end
      if (handshake) begin
        beat_q <= wr_n_q ? 2'd0 : 2'd1;
      end
      if (state == S_WBURST) begin
        beat_q <= beat_q + 2'd1;
      end
      if (state == S_RBURST) begin
        rdata_q <= put_byte(rdata_q, beat_q, bus_data_i);
        beat_q  <= beat_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Scoreboard bench for reg_port_arbiter: stimulus pushes expected grants,
// bus handshakes, write bytes and responses; a negedge monitor pops/compares.
`timescale 1ns/1ps
module tb_reg_port_arbiter;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ-1:0]   req_wr_n_i = '0;
  logic [NREQ*2-1:0] req_addr_i = '0;
  logic [NREQ*32-1:0] req_wdata_i = '0;
  logic [NREQ-1:0]   rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              bus_valid_o;
  logic              bus_ready_i = 1'b0;
  logic              bus_wr_n_o;
  logic [1:0]        bus_addr_o;
  logic [7:0]        bus_data_o;
  logic [7:0]        bus_data_i = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed { int id; logic [31:0] rdata; logic err; int lat; } rsp_t;
  typedef struct packed { logic wr_n; logic [1:0] addr; } bus_t;

  rsp_t       exp_rsp[$];
  bus_t       exp_bus[$];
  logic [7:0] exp_byte[$];
  int         exp_grant[$];
  int         grant_cyc[$];
  int         wb_left = 0;

  reg_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_wr_n_i  (req_wr_n_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .bus_valid_o (bus_valid_o),
    .bus_ready_i (bus_ready_i),
    .bus_wr_n_o  (bus_wr_n_o),
    .bus_addr_o  (bus_addr_o),
    .bus_data_o  (bus_data_o),
    .bus_data_i  (bus_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  // Monitor
  rsp_t       m_r;
  bus_t       m_b;
  int         m_g;
  logic [7:0] m_byte;
  always @(negedge clk) begin
    if (!rst_n) begin
      wb_left = 0;
    end else begin
      if (!bus_valid_o) chk("bus_idle_fields", {29'd0, bus_wr_n_o, bus_addr_o}, 32'd0);
      if (!bus_valid_o && wb_left == 0) chk("bus_idle_data", {24'd0, bus_data_o}, 32'd0);
      if (req_ready_o != '0) begin
        grant_cyc.push_back(cyc);
        if (exp_grant.size() == 0) chk("grant_unexpected", {30'd0, req_ready_o}, 32'd0);
        else begin
          m_g = exp_grant.pop_front();
          chk("grant_owner", {30'd0, req_ready_o}, {30'd0, onehot(m_g)});
        end
      end
      if (wb_left > 0) begin
        m_byte = (exp_byte.size() > 0) ? exp_byte.pop_front() : 8'hxx;
        chk("wburst_byte", {24'd0, bus_data_o}, {24'd0, m_byte});
        wb_left--;
      end
      if (bus_valid_o && bus_ready_i) begin
        if (exp_bus.size() == 0) chk("handshake_unexpected", 32'd1, 32'd0);
        else begin
          m_b = exp_bus.pop_front();
          chk("handshake_cmd", {29'd0, bus_wr_n_o, bus_addr_o}, {29'd0, m_b.wr_n, m_b.addr});
          if (!bus_wr_n_o) begin
            m_byte = (exp_byte.size() > 0) ? exp_byte.pop_front() : 8'hxx;
            chk("byte0", {24'd0, bus_data_o}, {24'd0, m_byte});
            wb_left = 3;
          end
        end
      end
      if (rsp_valid_o != '0) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", {30'd0, rsp_valid_o}, 32'd0);
        else begin
          m_r = exp_rsp.pop_front();
          chk("rsp_owner", {30'd0, rsp_valid_o}, {30'd0, onehot(m_r.id)});
          chk("rsp_rdata", rsp_rdata_o, m_r.rdata);
          chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, m_r.err});
          m_g = (grant_cyc.size() > 0) ? grant_cyc.pop_front() : -1000;
          chk("rsp_latency", cyc - m_g, m_r.lat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic wr_n, input logic [1:0] addr, input logic [31:0] wdata);
    req_wr_n_i[id]         = wr_n;
    req_addr_i[id*2 +: 2]  = addr;
    req_wdata_i[id*32 +: 32] = wdata;
  endtask

  task automatic expect_txn(input int id, input logic wr_n, input logic [1:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic err, input int lat, input bit hs);
    exp_grant.push_back(id);
    if (hs) begin
      exp_bus.push_back('{wr_n: wr_n, addr: addr});
      if (!wr_n) for (int k = 0; k < 4; k++) exp_byte.push_back(wdata[k*8 +: 8]);
    end
    exp_rsp.push_back('{id: id, rdata: rdata, err: err, lat: lat});
  endtask

  task automatic clear_queues();
    exp_rsp.delete(); exp_bus.delete(); exp_byte.delete();
    exp_grant.delete(); grant_cyc.delete();
  endtask

  task automatic wait_grant(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready_o[id]) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    if (!ok) chk("grant_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_rsp.size() != 0; i++) tick();
    if (exp_rsp.size() != 0) begin
      chk("rsp_wait_expired", exp_rsp.size(), 32'd0);
      clear_queues();
    end
  endtask

  task automatic do_txn(input int id, input logic wr_n, input logic [1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rbytes,
                        input logic [31:0] exp_rdata, input int delay);
    bit ok;
    set_req(id, wr_n, addr, wdata);
    expect_txn(id, wr_n, addr, wdata, exp_rdata, 1'b0, wr_n ? 6 + delay : 5 + delay, 1'b1);
    req_valid_i[id] = 1'b1;
    wait_grant(id, ok);
    if (!ok) begin req_valid_i[id] = 1'b0; clear_queues(); return; end
    tick();
    req_valid_i[id] = 1'b0;
    repeat (delay) tick();
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i = 1'b0;
    if (wr_n) begin
      for (int k = 0; k < 4; k++) begin
        bus_data_i = rbytes[k*8 +: 8];
        tick();
      end
      bus_data_i = 8'h00;
    end
    drain(30);
  endtask

  localparam logic [31:0] ALT_D0 = 32'h0102_0304;
  localparam logic [31:0] ALT_D1 = 32'hCAFE_BABE;

  task automatic alt_expect(input int n);
    set_req(0, 1'b0, 2'd0, ALT_D0);
    set_req(1, 1'b0, 2'd3, ALT_D1);
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 0) expect_txn(0, 1'b0, 2'd0, ALT_D0, 32'd0, 1'b0, 5, 1'b1);
      else            expect_txn(1, 1'b0, 2'd3, ALT_D1, 32'd0, 1'b0, 5, 1'b1);
    end
  endtask

  task automatic alt_run(input int n);
    int cnt;
    cnt = 0;
    bus_ready_i = 1'b1;
    req_valid_i = '1;
    for (int i = 0; i < 200 && cnt < n; i++) begin
      #1;
      if (req_ready_o != '0) cnt++;
      @(posedge clk);
      #1;
    end
    req_valid_i = '0;
    if (cnt < n) chk("alt_grants", cnt, n);
    drain(40);
    bus_ready_i = 1'b0;
  endtask

  initial begin
    bit ok;
    // Reset with both requesters already pending.
    repeat (3) tick();
    alt_expect(4);
    req_valid_i = '1;
    #1;
    chk("reset_outputs", {15'd0, req_ready_o, rsp_valid_o, rsp_err_o, bus_valid_o,
                          bus_wr_n_o, bus_addr_o, bus_data_o}, 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'd0);
    rst_n = 1'b1;
    alt_run(4);

    // Directed transactions.
    do_txn(0, 1'b0, 2'd2, 32'hA1B2_C3D4, 32'd0,        32'd0,        0);
    do_txn(1, 1'b1, 2'd1, 32'd0,        32'h4433_2211, 32'h4433_2211, 0);
    do_txn(1, 1'b1, 2'd0, 32'd0,        32'hF00F_A55A, 32'hF00F_A55A, 7);
    do_txn(0, 1'b0, 2'd3, 32'h00FF_807F, 32'd0,        32'd0,        3);

    // Reset in the middle of a read burst (H+2).
    set_req(0, 1'b1, 2'd3, 32'd0);
    exp_grant.push_back(0);
    exp_bus.push_back('{wr_n: 1'b1, addr: 2'd3});
    req_valid_i[0] = 1'b1;
    wait_grant(0, ok);
    tick();
    req_valid_i[0] = 1'b0;
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i = 1'b0;
    bus_data_i = 8'h77;
    tick();
    req_valid_i = '1;
    rst_n = 1'b0;
    #1;
    chk("midburst_reset_outputs", {15'd0, req_ready_o, rsp_valid_o, rsp_err_o, bus_valid_o,
                                   bus_wr_n_o, bus_addr_o, bus_data_o}, 32'd0);
    chk("midburst_reset_rdata", rsp_rdata_o, 32'd0);
    bus_data_i = 8'h00;
    clear_queues();
    tick();
    tick();
    alt_expect(2);
    rst_n = 1'b1;
    alt_run(2);

`ifdef REG_ARB_TIMEOUT_EN
    set_req(0, 1'b0, 2'd2, 32'hDEAD_BEEF);
    expect_txn(0, 1'b0, 2'd2, 32'hDEAD_BEEF, 32'd0, 1'b1, TIMEOUT + 1, 1'b0);
    req_valid_i[0] = 1'b1;
    wait_grant(0, ok);
    tick();
    req_valid_i[0] = 1'b0;
    drain(TIMEOUT + 20);
`endif

    repeat (4) tick();
    chk("leftover_expectations", exp_bus.size() + exp_byte.size() + exp_grant.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
